// File: rtl/fft_unloader.sv
// Reads the in-place FFT result RAM in bit-reversed order and streams the bins out in natural order.
// A 2-entry FIFO (head = out_data register) absorbs the RAM read latency under backpressure.
module fft_unloader #(
  parameter int N_samples = 8,
  parameter int DATA_W    = 32,
  localparam int AW       = $clog2(N_samples)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [AW-1:0]     out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [AW:0]   IDX_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] BIN_ONE  = AW'(1);
  localparam logic [AW-1:0] BIN_LAST = AW'(N_samples - 1);

  state_t              state, state_nxt;
  logic [AW:0]         rd_idx;
  logic                inflight;
  logic [1:0]          cnt, cnt_nxt;
  logic [DATA_W-1:0]   skid;
  logic                push, pop, issue, kick;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  assign kick = (state == IDLE) && start;
  assign push = inflight;
  assign pop  = out_valid & out_ready;

  // A read is launched only if its word is guaranteed a slot: words held plus the
  // word returning now, minus the word leaving now, must leave room for one more.
  // rd_en therefore follows out_ready within the cycle so a draining stream never bubbles.
  assign issue = (state == RUN) && !rd_idx[AW] &&
                 (({1'b0, cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  assign rd_en    = issue;
  assign rd_addr  = bitrev(rd_idx[AW-1:0]);
  assign out_last = out_valid && (out_index == BIN_LAST);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign cnt_nxt  = cnt + {1'b0, push} - {1'b0, pop};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (pop && out_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx    <= '0;
      out_index <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (kick) begin
        rd_idx    <= '0;
        out_index <= '0;
      end else begin
        if (issue)               rd_idx    <= rd_idx + IDX_ONE;
        if (pop && !out_last)    out_index <= out_index + BIN_ONE;
      end
    end
  end

  // out_data is the FIFO head; skid is the second slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid      <= '0;
    end else begin
      cnt       <= cnt_nxt;
      out_valid <= (cnt_nxt != 2'd0);
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) out_data <= rd_data;
          else             skid     <= rd_data;
        end
        2'b01: begin
          if (cnt == 2'd2) out_data <= skid;
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            out_data <= skid;
            skid     <= rd_data;
          end else begin
            out_data <= rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_unloader.sv
// Directed + randomized bench for fft_unloader against a bin-order reference model.
module tb_fft_unloader;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          out_last;
  logic          busy;
  logic          done;

  fft_unloader #(.N_samples(N), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [N];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int n_chk = 0, n_pass = 0;
  int n_rx, issued, cyc, first_x, last_x, done_cyc, done_cnt;
  bit rnd_ready = 0;
  bit ready_next = 0;
  logic [DW-1:0] exp_data [N];

  function automatic int brev(int k);
    int r = 0;
    for (int b = 0; b < AW; b++) if (((k >> b) & 1) != 0) r += (1 << (AW - 1 - b));
    return r;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Bin k lives at address bitrev(k); the stream must present bins 0..N-1.
  task automatic load_mem(bit rnd);
    for (int a = 0; a < N; a++) mem[a] = rnd ? DW'($urandom) : DW'(32'hA0 + a);
    for (int k = 0; k < N; k++) exp_data[k] = mem[brev(k)];
  endtask

  task automatic clear_sb();
    n_rx = 0; issued = 0; cyc = 0;
    first_x = -1; last_x = -1; done_cyc = -1; done_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_next;
    #3;
    cyc++;
    if (rd_en) issued++;
    if (out_valid) begin
      if (n_rx < N) begin
        check("data", out_data, exp_data[n_rx]);
        check("index", out_index, n_rx);
        check("last", out_last, n_rx == N - 1);
      end else begin
        check("extra_valid", out_valid, 0);
      end
      if (out_ready) begin
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        n_rx++;
      end
    end
    check("occupancy", (issued - n_rx) <= 2, 1);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("done_after_last", n_rx, N);
    end
  endtask

  task automatic run_to_done(int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      step();
      k++;
    end
    check("finished", done_cnt, 1);
    step();
    check("busy_after", busy, 0);
    check("done_once", done_cnt, 1);
    check("all_words", n_rx, N);
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    // 1: reset holds everything quiet even with start/ready asserted
    clear_sb();
    load_mem(0);
    out_ready = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #4;
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_index", out_index, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    start = 1'b0;
    rst_n = 1'b1;
    ready_next = 1'b1;
    step();
    step();

    // 2: full-rate stream, latency and done pulse
    clear_sb();
    kick();
    check("c1_rd_en", rd_en, 1);
    check("c1_addr", rd_addr, 0);
    check("c1_busy", busy, 1);
    check("c1_valid", out_valid, 0);
    step();
    check("c2_valid", out_valid, 0);
    run_to_done(40);
    check("first_xfer", first_x, 3);
    check("last_xfer", last_x, 10);
    check("done_cycle", done_cyc, 11);

    // 3: stalled from the start, then released
    clear_sb();
    ready_next = 1'b0;
    kick();
    repeat (9) step();
    check("stall_reads", issued, 2);
    check("stall_valid", out_valid, 1);
    check("stall_data", out_data, 32'hA0);
    ready_next = 1'b1;
    run_to_done(40);

    // 4: random data, random backpressure
    load_mem(1);
    clear_sb();
    rnd_ready = 1;
    kick();
    run_to_done(300);
    rnd_ready = 0;

    // 5: start re-pulsed mid-stream and during DONE
    load_mem(0);
    clear_sb();
    kick();
    for (int k = 0; k < 60 && done_cnt == 0; k++) begin
      start = (n_rx == 2 || n_rx == 7);
      step();
    end
    check("restart_done", done_cnt, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("restart_busy", busy, 0);
    check("restart_reads", issued, N);
    check("restart_words", n_rx, N);
    check("restart_valid", out_valid, 0);

    // 6: async reset mid-stream, then a clean restart
    clear_sb();
    kick();
    for (int k = 0; k < 30 && n_rx < 3; k++) step();
    check("pre_reset_words", n_rx, 3);
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_index", out_index, 0);
    check("arst_busy", busy, 0);
    check("arst_rd_en", rd_en, 0);
    check("arst_last", out_last, 0);
    #2;
    rst_n = 1'b1;
    clear_sb();
    kick();
    run_to_done(40);
    check("post_reset_first", first_x, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
